// File: rtl/fp_stream_pkg.sv
// Shared types and latency constants for the go/done FP-unit stream issuers.
package fp_stream_pkg;

   localparam int FP_WIDTH       = 32;
   localparam int FP_SUB_LATENCY = 14;
   localparam int FP_ADD_LATENCY = 14;
   localparam int FP_MUL_LATENCY = 10;

   typedef logic [FP_WIDTH-1:0] fp_word_t;

   typedef enum logic [0:0] {
      FLUSH = 1'b0,
      RUN   = 1'b1
   } issuer_state_t;

endpackage

// File: rtl/fp_stream_issuer_if.sv
// Operand stream, FP-unit go/done pair and result stream of one issuer.
interface fp_stream_issuer_if
   import fp_stream_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             unit_go;
   logic [WIDTH-1:0] unit_a;
   logic [WIDTH-1:0] unit_b;
   logic             unit_done;
   logic [WIDTH-1:0] unit_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             err_done;

   // master is the issuer itself, slave is everything around it
   modport master (
      input  in_valid, in_a, in_b, unit_done, unit_result, out_ready,
      output in_ready, unit_go, unit_a, unit_b, out_valid, out_data, err_done
   );

   modport slave (
      output in_valid, in_a, in_b, unit_done, unit_result, out_ready,
      input  in_ready, unit_go, unit_a, unit_b, out_valid, out_data, err_done
   );

endinterface

// File: rtl/sync_fifo.sv
// In-order FIFO whose head entry sits in its own register, so data_o is a flop output.
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    rd_next_s;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + AW'(1);
      end
   endfunction

   always_comb begin
      rd_next_s = ptr_inc(rd_ptr_q);
      wr_ptr_d  = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop_i ? rd_next_s : rd_ptr_q;
      count_d   = count_q + CW'(push_i) - CW'(pop_i);
      // A push bypasses into the head register whenever the head would otherwise be empty.
      if (push_i && ((count_q == '0) || (pop_i && (count_q == CW'(1))))) begin
         head_d = push_data_i;
      end else if (pop_i && (count_q > CW'(1))) begin
         head_d = mem_q[rd_next_s];
      end else begin
         head_d = head_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign data_o  = head_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/fp_stream_issuer.sv
// Issues operand pairs to a fixed-latency go/done FP unit and returns its results in
// order; credits (inflight + queued) never exceed the FIFO depth, so no result is lost.
module fp_stream_issuer
   import fp_stream_pkg::*;
#(
   parameter int WIDTH   = FP_WIDTH,
   parameter int LATENCY = FP_SUB_LATENCY,
   parameter int DEPTH   = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   fp_stream_issuer_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = $clog2(LATENCY + 1);

   issuer_state_t    state_q, state_d;
   logic [LW-1:0]    flush_cnt_q, flush_cnt_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic             err_q, err_d;
   logic             ready_s, issue_s, push_s, pop_s;
   logic             empty_s, full_s;
   logic [CW-1:0]    count_s;
   logic [CW:0]      credit_s;
   logic [WIDTH-1:0] fifo_data_s;

   assign credit_s = {1'b0, inflight_q} + {1'b0, count_s};
   assign pop_s    = !empty_s && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      inflight_d  = inflight_q;
      err_d       = err_q;
      ready_s     = 1'b0;
      issue_s     = 1'b0;
      push_s      = 1'b0;
      case (state_q)
         FLUSH: begin
            // The unit is never reset: any done seen here is stale and is ignored.
            if (flush_cnt_q <= LW'(1)) begin
               state_d = RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - LW'(1);
            end
         end
         RUN: begin
            ready_s = (credit_s < (CW + 1)'(DEPTH)) && !full_s;
            issue_s = bus.in_valid && ready_s;
            if (bus.unit_done) begin
               if (inflight_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  push_s = 1'b1;
               end
            end else begin
               push_s = 1'b0;
            end
            if (issue_s && !push_s) begin
               inflight_d = inflight_q + CW'(1);
            end else if (!issue_s && push_s) begin
               inflight_d = inflight_q - CW'(1);
            end else begin
               inflight_d = inflight_q;
            end
         end
         default: begin
            state_d     = FLUSH;
            flush_cnt_d = LW'(LATENCY);
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FLUSH;
         flush_cnt_q <= LW'(LATENCY);
         inflight_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push_i      (push_s),
      .push_data_i (bus.unit_result),
      .pop_i       (pop_s),
      .data_o      (fifo_data_s),
      .empty_o     (empty_s),
      .full_o      (full_s),
      .count_o     (count_s)
   );

   assign bus.in_ready  = ready_s;
   assign bus.unit_go   = issue_s;
   assign bus.unit_a    = bus.in_a;
   assign bus.unit_b    = bus.in_b;
   assign bus.out_valid = !empty_s;
   assign bus.out_data  = fifo_data_s;
   assign bus.err_done  = err_q;

endmodule

// File: tb/tb_fp_stream_issuer.sv
// Bench for fp_stream_issuer: behavioural 14-cycle FPSub32 unit plus a queue-based
// reference model of credits, flush window and result ordering.
module tb_fp_stream_issuer;
   import fp_stream_pkg::*;

   localparam int LAT = 14;
   localparam int DEP = 16;

   logic clock;
   logic reset_n;

   fp_stream_issuer_if #(.WIDTH(FP_WIDTH)) bus ();

   fp_stream_issuer #(
      .WIDTH   (FP_WIDTH),
      .LATENCY (LAT),
      .DEPTH   (DEP)
   ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic real sp2r(input fp_word_t x);
      logic [63:0] d;
      if (x[30:0] == 31'd0) begin
         d = {x[31], 63'd0};
      end else begin
         d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
      end
      return $bitstoreal(d);
   endfunction

   // Single-precision subtract for normal operands, result truncated.
   function automatic fp_word_t fpsub(input fp_word_t a, input fp_word_t b);
      real         r;
      logic [63:0] d;
      logic [10:0] e;
      r = sp2r(a) - sp2r(b);
      d = $realtobits(r);
      if (d[62:0] == 63'd0) begin
         return {d[63], 31'd0};
      end
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic fp_word_t rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      e = 8'($urandom_range(110, 140));
      m = 23'($urandom);
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   // Behavioural FP unit: no reset, result appears LAT cycles after go.
   logic [LAT-1:0]               pipe_v = '0;
   logic [LAT-1:0][FP_WIDTH-1:0] pipe_d = '0;
   logic                         spur_v = 1'b0;
   fp_word_t                     spur_d = '0;

   always @(posedge clock) begin
      pipe_v <= {pipe_v[LAT-2:0], bus.unit_go};
      pipe_d <= {pipe_d[LAT-2:0], fpsub(bus.unit_a, bus.unit_b)};
   end

   assign bus.unit_done   = pipe_v[LAT-1] | spur_v;
   assign bus.unit_result = spur_v ? spur_d : pipe_d[LAT-1];

   // Reference model state
   bit       m_run;
   int       m_flush;
   int       m_inflight;
   bit       m_err;
   fp_word_t m_fifo[$];
   fp_word_t m_issue[$];

   int       cyc = 0;
   int       dut_go_cnt = 0;
   int       dut_pop_cnt = 0;
   int       triple_cnt = 0;
   int       first_valid_cyc = -1;
   fp_word_t first_valid_data = '0;

   task automatic step(input logic v, input fp_word_t a, input fp_word_t b,
                       input logic ordy, input logic spur, input fp_word_t sd);
      bit       exp_rdy, acc, pop, done;
      fp_word_t res;
      @(negedge clock);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = ordy;
      spur_v        = spur;
      spur_d        = sd;
      #1;
      exp_rdy = m_run && ((m_inflight + m_fifo.size()) < DEP);
      acc     = v && exp_rdy;
      pop     = (m_fifo.size() > 0) && ordy;
      check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check_eq("unit_go", 32'(bus.unit_go), 32'(acc));
      if (acc) begin
         check_eq("unit_a", bus.unit_a, a);
         check_eq("unit_b", bus.unit_b, b);
      end
      check_eq("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         check_eq("out_data", bus.out_data, m_fifo[0]);
      end
      check_eq("err_done", 32'(bus.err_done), 32'(m_err));
      if (bus.unit_go) dut_go_cnt++;
      if (bus.out_valid && ordy) dut_pop_cnt++;
      if (bus.unit_go && bus.unit_done && bus.out_valid && ordy) triple_cnt++;
      if (first_valid_cyc < 0 && bus.out_valid) begin
         first_valid_cyc  = cyc;
         first_valid_data = bus.out_data;
      end
      done = bus.unit_done;
      res  = bus.unit_result;
      if (pop) void'(m_fifo.pop_front());
      if (m_run && done) begin
         if (m_inflight == 0) begin
            m_err = 1'b1;
         end else begin
            check_eq("unit_order", res, m_issue.pop_front());
            check_eq("no_push_when_full", 32'(m_fifo.size() < DEP), 32'd1);
            m_fifo.push_back(res);
            m_inflight--;
         end
      end
      if (acc) begin
         m_issue.push_back(fpsub(a, b));
         m_inflight++;
      end
      if (!m_run) begin
         if (m_flush <= 1) m_run = 1'b1;
         else m_flush--;
      end
      cyc++;
      @(posedge clock);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, '0);
   endtask

   task automatic stream(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b1, rand_fp(), rand_fp(), ordy, 1'b0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (m_fifo.size() > 0 || m_inflight > 0); i++) begin
         step(1'b0, '0, '0, 1'b1, 1'b0, '0);
      end
      check_eq("drain_done", 32'(m_fifo.size() + m_inflight), 32'd0);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clock);
      reset_n       = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'h3F800000;
      bus.in_b      = 32'h3F800000;
      bus.out_ready = 1'b1;
      spur_v        = 1'b0;
      #1;
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_unit_go", 32'(bus.unit_go), 32'd0);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_data", bus.out_data, 32'd0);
      check_eq("rst_err_done", 32'(bus.err_done), 32'd0);
      m_run      = 1'b0;
      m_flush    = LAT;
      m_inflight = 0;
      m_err      = 1'b0;
      m_fifo.delete();
      m_issue.delete();
      repeat (n) @(posedge clock);
      #2;
      reset_n      = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   task automatic single_op(input string tag, input fp_word_t a, input fp_word_t b,
                            input fp_word_t exp);
      int acc_cyc;
      acc_cyc         = cyc;
      first_valid_cyc = -1;
      step(1'b1, a, b, 1'b1, 1'b0, '0);
      for (int i = 0; i < 40 && first_valid_cyc < 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0, '0);
      check_eq({tag, "_latency"}, 32'(first_valid_cyc - acc_cyc), 32'(LAT + 1));
      check_eq({tag, "_data"}, first_valid_data, exp);
   endtask

   initial begin
      int go0, pop0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      apply_reset(3);
      idle(LAT, 1'b1);

      // 1: single op, 3.0 - 1.0
      single_op("t1", 32'h40400000, 32'h3F800000, 32'h40000000);
      drain();

      // 2: 100 back-to-back with free-flowing output
      go0 = dut_go_cnt; pop0 = dut_pop_cnt;
      stream(100, 1'b1);
      check_eq("t2_issued", 32'(dut_go_cnt - go0), 32'd100);
      drain();
      check_eq("t2_results", 32'(dut_pop_cnt - pop0), 32'd100);

      // 3: backpressure fills exactly DEPTH credits
      go0 = dut_go_cnt; pop0 = dut_pop_cnt;
      stream(40, 1'b0);
      #1;
      check_eq("t3_issued", 32'(dut_go_cnt - go0), 32'(DEP));
      check_eq("t3_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("t3_full", 32'(m_fifo.size()), 32'(DEP));
      drain();
      check_eq("t3_drained", 32'(dut_pop_cnt - pop0), 32'(DEP));

      // 4: steady state has issue + done + pop in the same cycle
      triple_cnt = 0;
      stream(30, 1'b1);
      check_eq("t4_triples", 32'(triple_cnt), 32'(30 - LAT - 1));
      drain();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, rand_fp(), rand_fp(),
              $urandom_range(0, 2) != 0, 1'b0, '0);
      end
      drain();

      // 5: reset with 10 operations in flight
      stream(10, 1'b1);
      apply_reset(2);
      idle(LAT, 1'b1);
      #1;
      check_eq("t5_err_done", 32'(bus.err_done), 32'd0);
      single_op("t5", 32'h40A00000, 32'h3F800000, 32'h40800000);
      drain();

      // 6: spurious done with nothing in flight
      step(1'b0, '0, '0, 1'b1, 1'b1, 32'hDEADBEEF);
      idle(5, 1'b1);
      #1;
      check_eq("t6_err_sticky", 32'(bus.err_done), 32'd1);
      check_eq("t6_fifo_empty", 32'(bus.out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
